multicycle_control: RTL and testbench

Multicycle control unit for the ARM-subset datapath. It decodes the registered instruction fields and steps a main FSM through the fetch, decode, execute, memory and writeback cycles. It also holds the NZCV flags and evaluates the condition field. It drives `immsrc[1:0]` straight into the immediate extension unit, together with every other datapath mux select and write enable.

---
 rtl/mc_pkg.sv | 139 +++++++++++++
 rtl/cond_logic.sv | 84 ++++++++
 rtl/multicycle_control.sv | 108 ++++++++++
 tb/tb_multicycle_control.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Build option: MC_COND_EXEC_EN enables ARM conditional execution.
package mc_pkg;

  localparam int unsigned INSTR_W = 20;
  localparam int unsigned FLAGS_W = 4;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALUB_REG  = 2'b00;
  localparam logic [1:0] ALUB_IMM  = 2'b01;
  localparam logic [1:0] ALUB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Data-processing cmd field, funct[4:1]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Registered Moore controls driven to the datapath
  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
  } ctl_t;

  // Control encoding for a state, given the latched condition result
  function automatic ctl_t ctl_for(input state_t s, input logic cond,
                                   input logic cmp, input logic rd15);
    ctl_t c;
    logic wr;
    c  = '0;
    wr = 1'b0;
    case (s)
      S_FETCH: begin
        c.irwrite   = 1'b1;
        c.alusrca   = 1'b1;
        c.alusrcb   = ALUB_FOUR;
        c.resultsrc = RES_ALU;
        c.pcwrite   = 1'b1;
      end
      S_DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = ALUB_FOUR;
        c.resultsrc = RES_ALU;
      end
      S_MEMADR:   c.alusrcb = ALUB_IMM;
      S_MEMREAD:  c.adrsrc  = 1'b1;
      S_MEMWB: begin
        wr          = cond;
        c.resultsrc = RES_RDATA;
        c.regwrite  = wr;
        c.pcwrite   = wr & rd15;
      end
      S_MEMWRITE: begin
        c.adrsrc   = 1'b1;
        c.memwrite = cond;
      end
      S_EXECUTER: c.alusrcb = ALUB_REG;
      S_EXECUTEI: c.alusrcb = ALUB_IMM;
      S_ALUWB: begin
        wr         = cond & ~cmp;
        c.regwrite = wr;
        c.pcwrite  = wr & rd15;
      end
      S_BRANCH: begin
        c.alusrcb   = ALUB_IMM;
        c.resultsrc = RES_ALU;
        c.pcwrite   = cond;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // ALU operation for a data-processing cmd; unknown cmds fall back to ADD
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: return ALU_ADD;
      CMD_SUB: return ALU_SUB;
      CMD_CMP: return ALU_SUB;
      CMD_AND: return ALU_AND;
      CMD_ORR: return ALU_ORR;
      default: return ALU_ADD;
    endcase
  endfunction

  // Arithmetic ops are the only ones that produce meaningful C and V
  function automatic logic is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/cond_logic.sv
// NZCV flags register, condition check and latched condition result.
// Build option: MC_COND_EXEC_EN; when undefined every instruction executes.
module cond_logic
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         i_cond,
  input  logic [FLAGS_W-1:0] i_aluflags,
  input  logic               i_decode,
  input  logic               i_exec,
  input  logic               i_set_flags,
  input  logic               i_arith,
  output logic               o_cond_next
);

  logic [FLAGS_W-1:0] r_flags;
  logic               w_cond_q;
  logic               w_flag_we;

`ifdef MC_COND_EXEC_EN
  logic r_cond_q;
  logic w_cond_ok;
  logic w_n, w_z, w_c, w_v;

  // Evaluate the condition field against the current flags
  always_comb begin
    w_cond_ok = 1'b0;
    {w_n, w_z, w_c, w_v} = r_flags;
    case (i_cond)
      COND_EQ: w_cond_ok = w_z;
      COND_NE: w_cond_ok = ~w_z;
      COND_CS: w_cond_ok = w_c;
      COND_CC: w_cond_ok = ~w_c;
      COND_MI: w_cond_ok = w_n;
      COND_PL: w_cond_ok = ~w_n;
      COND_VS: w_cond_ok = w_v;
      COND_VC: w_cond_ok = ~w_v;
      COND_HI: w_cond_ok = w_c & ~w_z;
      COND_LS: w_cond_ok = ~w_c | w_z;
      COND_GE: w_cond_ok = (w_n == w_v);
      COND_LT: w_cond_ok = (w_n != w_v);
      COND_GT: w_cond_ok = ~w_z & (w_n == w_v);
      COND_LE: w_cond_ok = w_z | (w_n != w_v);
      COND_AL: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  // Latch the decision once per instruction so EXECUTE flag writes cannot alter it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cond_q <= 1'b0;
    end else if (i_decode) begin
      r_cond_q <= w_cond_ok;
    end
  end

  assign w_cond_q    = r_cond_q;
  // Value cond_q holds next cycle, needed by the registered control outputs
  assign o_cond_next = i_decode ? w_cond_ok : r_cond_q;
`else
  logic w_unused_cond;

  assign w_cond_q      = 1'b1;
  assign o_cond_next   = 1'b1;
  assign w_unused_cond = ^{i_cond, i_decode, r_flags};
`endif

  assign w_flag_we = i_exec & i_set_flags & w_cond_q;

  // NZ follow every flag-setting op; CV only arithmetic ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= '0;
    end else if (w_flag_we) begin
      r_flags[3:2] <= i_aluflags[3:2];
      if (i_arith) begin
        r_flags[1:0] <= i_aluflags[1:0];
      end
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit for the ARM-subset datapath: main FSM plus decoders.
// Build option: MC_COND_EXEC_EN enables conditional execution in cond_logic.
module multicycle_control
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic [FLAGS_W-1:0] aluflags,
  output logic               pcwrite,
  output logic               irwrite,
  output logic               memwrite,
  output logic               regwrite,
  output logic               adrsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         resultsrc,
  output logic [1:0]         immsrc,
  output logic [1:0]         regsrc,
  output logic [1:0]         alucontrol
);

  state_t     r_state;
  state_t     w_next_state;
  ctl_t       r_ctl;
  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic [3:0] w_cmd;
  logic       w_cmp;
  logic       w_rd15;
  logic       w_in_exec;
  logic       w_alu_state;
  logic       w_cond_next;
  logic       w_unused_rn;

  assign w_cond      = instr[19:16];
  assign w_op        = instr[15:14];
  assign w_funct     = instr[13:8];
  assign w_rd        = instr[3:0];
  assign w_unused_rn = ^instr[7:4];

  assign w_cmd       = w_funct[4:1];
  assign w_cmp       = (w_cmd == CMD_CMP);
  assign w_rd15      = (w_rd == 4'd15);
  assign w_in_exec   = (r_state == S_EXECUTER) || (r_state == S_EXECUTEI);
  assign w_alu_state = w_in_exec || (r_state == S_ALUWB);

  cond_logic u_cond (
    .clk         (clk),
    .reset       (reset),
    .i_cond      (w_cond),
    .i_aluflags  (aluflags),
    .i_decode    (r_state == S_DECODE),
    .i_exec      (w_in_exec),
    .i_set_flags (w_funct[0]),
    .i_arith     (is_arith(w_cmd)),
    .o_cond_next (w_cond_next)
  );

  // Next-state selection for the main FSM
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_MEM:  w_next_state = S_MEMADR;
          OP_DP:   w_next_state = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   w_next_state = S_BRANCH;
          default: w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next_state = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next_state = S_MEMWB;
      S_EXECUTER: w_next_state = S_ALUWB;
      S_EXECUTEI: w_next_state = S_ALUWB;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // State register with controls registered from the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ctl   <= ctl_for(S_FETCH, 1'b0, 1'b0, 1'b0);
    end else begin
      r_state <= w_next_state;
      r_ctl   <= ctl_for(w_next_state, w_cond_next, w_cmp, w_rd15);
    end
  end

  assign pcwrite   = r_ctl.pcwrite;
  assign irwrite   = r_ctl.irwrite;
  assign memwrite  = r_ctl.memwrite;
  assign regwrite  = r_ctl.regwrite;
  assign adrsrc    = r_ctl.adrsrc;
  assign alusrca   = r_ctl.alusrca;
  assign alusrcb   = r_ctl.alusrcb;
  assign resultsrc = r_ctl.resultsrc;

  // Instruction-field decodes; instr is held stable by the IR after FETCH
  assign immsrc     = w_op;
  assign regsrc     = {w_op == OP_MEM, w_op == OP_BR};
  assign alucontrol = w_alu_state ? alu_decode(w_cmd) : ALU_ADD;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (honours MC_COND_EXEC_EN).
module tb_multicycle_control;

`ifdef MC_COND_EXEC_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3,
                 ST_MEMWB = 4, ST_MEMWRITE = 5, ST_EXR = 6, ST_EXI = 7,
                 ST_ALUWB = 8, ST_BRANCH = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] instr;
  logic [3:0]  aluflags;
  logic        pcwrite, irwrite, memwrite, regwrite, adrsrc, alusrca;
  logic [1:0]  alusrcb, resultsrc, immsrc, regsrc, alucontrol;

  int          errors = 0;
  int          checks = 0;
  logic [3:0]  m_flags;
  logic [15:0] exp_q[$];
  string       lbl_q[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .instr(instr), .aluflags(aluflags),
    .pcwrite(pcwrite), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .adrsrc(adrsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .resultsrc(resultsrc), .immsrc(immsrc),
    .regsrc(regsrc), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] act_vec();
    return {pcwrite, irwrite, memwrite, regwrite, adrsrc, alusrca,
            alusrcb, resultsrc, immsrc, regsrc, alucontrol};
  endfunction

  function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    if (!COND_EN) return 1'b1;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] exp_vec(input int st, input logic c,
      input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
    logic pcw, irw, mw, rw, adr, asa, cmp, r15;
    logic [1:0] asb, rs, alc;
    {pcw, irw, mw, rw, adr, asa} = 6'b0;
    asb = 2'b00; rs = 2'b00; alc = 2'b00;
    cmp = (fn[4:1] == 4'b1010);
    r15 = (rd == 4'd15);
    case (st)
      ST_FETCH:    begin irw = 1; asa = 1; asb = 2'b10; rs = 2'b10; pcw = 1; end
      ST_DECODE:   begin asa = 1; asb = 2'b10; rs = 2'b10; end
      ST_MEMADR:   asb = 2'b01;
      ST_MEMREAD:  adr = 1;
      ST_MEMWB:    begin rs = 2'b01; rw = c; pcw = c & r15; end
      ST_MEMWRITE: begin adr = 1; mw = c; end
      ST_EXI:      asb = 2'b01;
      ST_ALUWB:    begin rw = c & ~cmp; pcw = c & ~cmp & r15; end
      ST_BRANCH:   begin asb = 2'b01; rs = 2'b10; pcw = c; end
      default: ;
    endcase
    if (st == ST_EXR || st == ST_EXI || st == ST_ALUWB) begin
      case (fn[4:1])
        4'b0100: alc = 2'b00;
        4'b0010: alc = 2'b01;
        4'b1010: alc = 2'b01;
        4'b0000: alc = 2'b10;
        4'b1100: alc = 2'b11;
        default: alc = 2'b00;
      endcase
    end
    return {pcw, irw, mw, rw, adr, asa, asb, rs, op, (op == 2'b01), (op == 2'b10), alc};
  endfunction

  // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 in the next FETCH.
  task automatic run_instr(input string name, input logic [3:0] cc, input logic [1:0] op,
                           input logic [5:0] fn, input logic [3:0] rd, input logic [3:0] af);
    int seq[$];
    logic c;
    instr    = {cc, op, fn, 4'h2, rd};
    aluflags = af;
    c = cond_holds(cc, m_flags);
    seq = '{ST_FETCH, ST_DECODE};
    case (op)
      2'b01: begin
        seq.push_back(ST_MEMADR);
        if (fn[0]) begin seq.push_back(ST_MEMREAD); seq.push_back(ST_MEMWB); end
        else seq.push_back(ST_MEMWRITE);
      end
      2'b00: begin seq.push_back(fn[5] ? ST_EXI : ST_EXR); seq.push_back(ST_ALUWB); end
      2'b10: seq.push_back(ST_BRANCH);
      default: ;
    endcase
    foreach (seq[k]) begin
      exp_q.push_back(exp_vec(seq[k], c, op, fn, rd));
      lbl_q.push_back(name);
    end
    for (int i = 0; i < seq.size(); i++) begin
      logic [15:0] e, a;
      string l;
      @(negedge clk);
      e = exp_q.pop_front();
      l = lbl_q.pop_front();
      a = act_vec();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b expected %b", l, i, a, e);
      end
      @(posedge clk); #1;
    end
    if (op == 2'b00 && fn[0] && c) begin
      m_flags[3:2] = af[3:2];
      if (fn[4:1] == 4'b0100 || fn[4:1] == 4'b0010 || fn[4:1] == 4'b1010)
        m_flags[1:0] = af[1:0];
    end
  endtask

  task automatic test_reset();
    logic [15:0] a;
    reset = 1'b1;
    instr = {4'hE, 2'b11, 6'h00, 8'h00};
    aluflags = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = act_vec();
    checks++;
    if (a !== 16'b1100_0110_1011_0000) begin
      errors++;
      $display("FAIL reset_fetch: got %b expected %b", a, 16'b1100_0110_1011_0000);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_flags = 4'h0;
    run_instr("nop_after_reset", 4'hE, 2'b11, 6'h00, 4'h0, 4'h0);
  endtask

  task automatic test_add_imm();
    run_instr("add_r1_imm5", 4'hE, 2'b00, 6'b101000, 4'd1, 4'h0);
  endtask

  task automatic test_ldr();
    run_instr("ldr_r3", 4'hE, 2'b01, 6'b011001, 4'd3, 4'h0);
  endtask

  task automatic test_str_cond();
    run_instr("str_eq_zclear", 4'h0, 2'b01, 6'b011000, 4'd4, 4'h0);
  endtask

  task automatic test_subs_beq();
    run_instr("subs_r0", 4'hE, 2'b00, 6'b000101, 4'd0, 4'b0100);
    run_instr("beq_taken", 4'h0, 2'b10, 6'b000000, 4'd0, 4'h0);
  endtask

  task automatic test_cmp();
    run_instr("cmp_pos", 4'hE, 2'b00, 6'b110101, 4'd0, 4'b0010);
    run_instr("beq_after_cmp", 4'h0, 2'b10, 6'b000011, 4'd0, 4'h0);
    run_instr("bcs_after_cmp", 4'h2, 2'b10, 6'b000011, 4'd0, 4'h0);
  endtask

  task automatic test_cond_latched();
    run_instr("addsne_sets_z", 4'h1, 2'b00, 6'b001001, 4'd5, 4'b0100);
    run_instr("ne_after_z", 4'h1, 2'b00, 6'b001000, 4'd6, 4'h0);
    run_instr("al_never_false", 4'hF, 2'b01, 6'b011000, 4'd6, 4'h0);
  endtask

  task automatic test_alu_ops();
    logic [5:0] fns[6];
    fns = '{6'b000000, 6'b011000, 6'b001000, 6'b000100, 6'b111110, 6'b010100};
    foreach (fns[k]) run_instr("alu_op", 4'hE, 2'b00, fns[k], 4'd7, 4'h0);
  endtask

  task automatic test_rd15();
    run_instr("add_pc", 4'hE, 2'b00, 6'b101000, 4'd15, 4'h0);
    run_instr("ldr_pc", 4'hE, 2'b01, 6'b011001, 4'd15, 4'h0);
    run_instr("cmp_rd15", 4'hE, 2'b00, 6'b110101, 4'd15, 4'b1000);
  endtask

  task automatic test_reset_mid();
    logic [15:0] a;
    run_instr("subs_set_z", 4'hE, 2'b00, 6'b000101, 4'd0, 4'b0100);
    instr = {4'hE, 2'b01, 6'b011001, 8'h23};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    a = act_vec();
    checks++;
    if (a !== 16'b0000_1000_0001_1000) begin
      errors++;
      $display("FAIL memread_before_reset: got %b expected %b", a, 16'b0000_1000_0001_1000);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_flags = 4'h0;
    run_instr("fetch_after_mid_reset", 4'hE, 2'b11, 6'h00, 4'h0, 4'h0);
    run_instr("beq_after_reset", 4'h0, 2'b10, 6'h00, 4'h0, 4'h0);
    run_instr("bne_after_reset", 4'h1, 2'b10, 6'h00, 4'h0, 4'h0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      run_instr("random", 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)),
                6'($urandom_range(63, 0)), 4'($urandom_range(15, 0)),
                4'($urandom_range(15, 0)));
    end
  endtask

  initial begin
    reset = 1'b1;
    instr = '0;
    aluflags = '0;
    m_flags = '0;
    test_reset();
    test_add_imm();
    test_ldr();
    test_str_cond();
    test_subs_beq();
    test_cmp();
    test_cond_latched();
    test_alu_ops();
    test_rd15();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
